mat_switch_port: RTL

Buffered, multi-entry switch interface for a MatCore-class core. It sits between the core's control unit and the inter-core switch.
- Send path: decouples control from switch backpressure with a SEND_DEPTH vector queue.
- Receive path: runs burst transfers of up to MAX_BURST vectors from a remote core into a RECV_DEPTH queue, with per-beat timeout detection.
- Supersedes the single-vector, unbuffered send/recv wiring of the current core.

---
 rtl/mat_switch_pkg.sv | 15 +
 rtl/mat_vec_fifo.sv | 54 +++++
 rtl/mat_switch_port.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mat_switch_pkg.sv
// Shared types for the MatCore switch port.
// Vector lanes are IEEE-754 double bit patterns.
package mat_switch_pkg;

   localparam int LANE_BITS         = 64;
   localparam int SWITCH_WIDTH_DFLT = 16;

   typedef enum logic [0:0] {
      RIDLE = 1'b0,
      RREQ  = 1'b1
   } MatSwitchRecvState_t;

   typedef logic [SWITCH_WIDTH_DFLT-1:0][LANE_BITS-1:0] MatSwitchVec_t;

endpackage

// File: rtl/mat_vec_fifo.sv
// Small vector FIFO with arbitrary (non power-of-2) depth.
// Head is read combinationally from storage, zero when empty.
module mat_vec_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   localparam int CW   = $clog2(DEPTH + 1),
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   // storage needs no reset: head is masked while empty
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= nxt(wr_ptr);
         if (do_pop)  rd_ptr <= nxt(rd_ptr);
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/mat_switch_port.sv
// Buffered switch port: send queue toward the switch and
// a burst receive engine with per-beat timeout.
module mat_switch_port
   import mat_switch_pkg::*;
#(
   parameter int SWITCH_WIDTH     = 16,
   parameter int SWITCH_CORE_SIZE = 4,
   parameter int SEND_DEPTH       = 4,
   parameter int RECV_DEPTH       = 4,
   parameter int MAX_BURST        = 8,
   parameter int TIMEOUT_CYCLES   = 256,
   localparam int CORE_ADDR_SIZE  = $clog2(SWITCH_CORE_SIZE),
   localparam int BURST_SIZE      = $clog2(MAX_BURST + 1)
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic                                   ctrl_send_valid,
   input  logic [CORE_ADDR_SIZE-1:0]              ctrl_send_core_idx,
   input  logic [SWITCH_WIDTH-1:0][LANE_BITS-1:0] ctrl_send_data,
   output logic                                   ctrl_send_accept,
   output logic                                   switch_send_ready,
   output logic [CORE_ADDR_SIZE-1:0]              switch_send_core_idx,
   output logic [SWITCH_WIDTH-1:0][LANE_BITS-1:0] switch_send_data,
   input  logic                                   switch_send_ok,
   input  logic                                   ctrl_recv_start,
   input  logic [CORE_ADDR_SIZE-1:0]              ctrl_recv_core_idx,
   input  logic [BURST_SIZE-1:0]                  ctrl_recv_len,
   output logic                                   ctrl_recv_busy,
   output logic                                   ctrl_recv_valid,
   output logic [SWITCH_WIDTH-1:0][LANE_BITS-1:0] ctrl_recv_data,
   input  logic                                   ctrl_recv_pop,
   output logic                                   switch_recv_request,
   output logic [CORE_ADDR_SIZE-1:0]              switch_recv_core_idx,
   input  logic                                   switch_recv_ready,
   input  logic [SWITCH_WIDTH-1:0][LANE_BITS-1:0] switch_recv_data,
   output logic                                   recv_timeout
);

   localparam int VW  = SWITCH_WIDTH * LANE_BITS;
   localparam int SW  = VW + CORE_ADDR_SIZE;
   localparam int SCW = $clog2(SEND_DEPTH + 1);
   localparam int RCW = $clog2(RECV_DEPTH + 1);
   localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [BURST_SIZE-1:0] B_MAX = BURST_SIZE'(MAX_BURST);

   logic                send_full;
   logic                send_empty;
   logic [SCW-1:0]      send_count;
   logic [SW-1:0]       send_head;
   logic                recv_full;
   logic                recv_empty;
   logic [RCW-1:0]      recv_count;
   logic [VW-1:0]       recv_head;

   MatSwitchRecvState_t state;
   logic [BURST_SIZE-1:0]     rem;
   logic [TW-1:0]             tcnt;
   logic [CORE_ADDR_SIZE-1:0] src_idx;
   logic                      beat;

   assign ctrl_send_accept  = (send_count != SCW'(SEND_DEPTH));
   assign switch_send_ready = !send_empty;
   assign {switch_send_core_idx, switch_send_data} = send_head;

   // destination index rides alongside the vector in each entry
   mat_vec_fifo #(.DEPTH(SEND_DEPTH), .WIDTH(SW)) u_send_q (
      .clock     (clock),
      .reset     (reset),
      .push      (ctrl_send_valid && !send_full),
      .push_data ({ctrl_send_core_idx, ctrl_send_data}),
      .pop       (switch_send_ok),
      .full      (send_full),
      .empty     (send_empty),
      .count     (send_count),
      .head      (send_head)
   );

   assign ctrl_recv_busy       = (state == RREQ);
   assign switch_recv_request  = ctrl_recv_busy &&
                                 (recv_count < RCW'(RECV_DEPTH));
   assign switch_recv_core_idx = ctrl_recv_busy ? src_idx : '0;
   assign beat                 = switch_recv_request && switch_recv_ready;
   assign ctrl_recv_valid      = !recv_empty;
   assign ctrl_recv_data       = recv_head;

   mat_vec_fifo #(.DEPTH(RECV_DEPTH), .WIDTH(VW)) u_recv_q (
      .clock     (clock),
      .reset     (reset),
      .push      (beat && !recv_full),
      .push_data (switch_recv_data),
      .pop       (ctrl_recv_pop),
      .full      (recv_full),
      .empty     (recv_empty),
      .count     (recv_count),
      .head      (recv_head)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= RIDLE;
         rem          <= '0;
         tcnt         <= '0;
         src_idx      <= '0;
         recv_timeout <= 1'b0;
      end else begin
         unique case (state)
            RIDLE: begin
               if (ctrl_recv_start && ctrl_recv_len != '0) begin
                  src_idx      <= ctrl_recv_core_idx;
                  rem          <= (ctrl_recv_len > B_MAX) ? B_MAX
                                                          : ctrl_recv_len;
                  tcnt         <= '0;
                  recv_timeout <= 1'b0;
                  state        <= RREQ;
               end
            end
            RREQ: begin
               if (beat) begin
                  rem  <= rem - 1'b1;
                  tcnt <= '0;
                  if (rem == BURST_SIZE'(1)) state <= RIDLE;
               end else if (switch_recv_request) begin
                  // only unanswered requests age the burst
                  tcnt <= tcnt + 1'b1;
                  if (tcnt == T_LAST) begin
                     recv_timeout <= 1'b1;
                     rem          <= '0;
                     state        <= RIDLE;
                  end
               end
            end
            default: state <= RIDLE;
         endcase
      end
   end

endmodule
